// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage sequencer for load/store handshakes with a variable-latency data memory
// Ports: clk/rst_n; EX/MEM inputs control_signals, aluresult, readdata2, newpc, inst20to16, inst15to11;
// holdreg stalls upstream; mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata form the memory handshake;
// WB_* are the registered MEM/WB outputs; mem_err is a sticky error flag.
module mem_stage_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  control_signals,
  input  logic [31:0] aluresult,
  input  logic [31:0] readdata2,
  input  logic [31:0] newpc,
  input  logic [4:0]  inst20to16,
  input  logic [4:0]  inst15to11,
  output logic        holdreg,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        WB_VALID,
  output logic        WB_REGWRITE,
  output logic [1:0]  WB_MEMTOREG,
  output logic [4:0]  WB_DEST,
  output logic [31:0] WB_ALURESULT,
  output logic [31:0] WB_READDATA,
  output logic [31:0] WB_NEWPC,
  output logic        mem_err
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr, r_wdata, r_newpc;
  logic        r_we, r_regwrite;
  logic [1:0]  r_memtoreg;
  logic [4:0]  r_dest;
  logic        w_memop, w_illegal, w_start, w_regwrite, w_tmo, w_hold;
  logic [4:0]  w_dest;
  assign w_memop    = control_signals[1] | control_signals[0];
  assign w_illegal  = (&control_signals[1:0]) | (w_memop & |aluresult[1:0]);
  assign w_start    = w_memop & !w_illegal;
  assign w_dest     = control_signals[6:5] == 2'b00 ? inst20to16 :
                      control_signals[6:5] == 2'b01 ? inst15to11 :
                      control_signals[6:5] == 2'b10 ? LINK_REG : 5'd0;
  assign w_regwrite = control_signals[2] & (control_signals[6:5] != 2'b11);
  assign w_tmo      = !mem_ack & (r_cnt == 8'(MEM_TIMEOUT - 1));
  // Memory outputs come only from captured state so they stay stable while upstream is frozen
  assign mem_req    = r_state == S_WAIT;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  // Gated by rst_n so the stall drops the instant reset asserts, even with a memop on the inputs
  assign holdreg    = rst_n & w_hold;
  always_comb begin
    w_hold = r_state == S_IDLE ? w_start : !(mem_ack | w_tmo);
    w_next = r_state == S_IDLE ? (w_start ? S_WAIT : S_IDLE) : (mem_ack | w_tmo ? S_IDLE : S_WAIT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_newpc      <= '0;
      r_we         <= 1'b0;
      r_regwrite   <= 1'b0;
      r_memtoreg   <= '0;
      r_dest       <= '0;
      mem_err      <= 1'b0;
      WB_VALID     <= 1'b0;
      WB_REGWRITE  <= 1'b0;
      WB_MEMTOREG  <= '0;
      WB_DEST      <= '0;
      WB_ALURESULT <= '0;
      WB_READDATA  <= '0;
      WB_NEWPC     <= '0;
    end else begin
      r_state      <= w_next;
      WB_VALID     <= 1'b0;
      WB_REGWRITE  <= 1'b0;
      WB_MEMTOREG  <= '0;
      WB_DEST      <= '0;
      WB_ALURESULT <= '0;
      WB_READDATA  <= '0;
      WB_NEWPC     <= '0;
      if (r_state == S_IDLE) begin
        if (w_illegal) mem_err <= 1'b1;
        if (w_start) begin
          r_cnt      <= '0;
          r_addr     <= aluresult;
          r_wdata    <= readdata2;
          r_newpc    <= newpc;
          r_we       <= control_signals[0];
          r_regwrite <= w_regwrite;
          r_memtoreg <= control_signals[4:3];
          r_dest     <= w_dest;
        end
        if (!w_memop) begin
          WB_VALID     <= 1'b1;
          WB_REGWRITE  <= w_regwrite;
          WB_MEMTOREG  <= control_signals[4:3];
          WB_DEST      <= w_dest;
          WB_ALURESULT <= aluresult;
          WB_NEWPC     <= newpc;
        end
      end else begin
        r_cnt <= r_cnt + 8'd1;
        if (w_tmo) mem_err <= 1'b1;
        if (mem_ack) begin
          WB_VALID     <= 1'b1;
          WB_REGWRITE  <= r_regwrite;
          WB_MEMTOREG  <= r_memtoreg;
          WB_DEST      <= r_dest;
          WB_ALURESULT <= r_addr;
          WB_READDATA  <= r_we ? 32'd0 : mem_rdata;
          WB_NEWPC     <= r_newpc;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;
  logic        clk = 0, rst_n = 1;
  logic [6:0]  control_signals = '0;
  logic [31:0] aluresult = '0, readdata2 = '0, newpc = '0, mem_rdata = '0;
  logic [4:0]  inst20to16 = '0, inst15to11 = '0;
  logic        mem_ack = 0;
  logic        holdreg, mem_req, mem_we, WB_VALID, WB_REGWRITE, mem_err;
  logic [31:0] mem_addr, mem_wdata, WB_ALURESULT, WB_READDATA, WB_NEWPC;
  logic [1:0]  WB_MEMTOREG;
  logic [4:0]  WB_DEST;
  int total = 0, bad = 0, hc, rc;

  mem_stage_ctrl #(.MEM_TIMEOUT(4), .LINK_REG(5'd31)) dut (
    .clk(clk), .rst_n(rst_n), .control_signals(control_signals), .aluresult(aluresult),
    .readdata2(readdata2), .newpc(newpc), .inst20to16(inst20to16), .inst15to11(inst15to11),
    .holdreg(holdreg), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .WB_VALID(WB_VALID),
    .WB_REGWRITE(WB_REGWRITE), .WB_MEMTOREG(WB_MEMTOREG), .WB_DEST(WB_DEST),
    .WB_ALURESULT(WB_ALURESULT), .WB_READDATA(WB_READDATA), .WB_NEWPC(WB_NEWPC), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs an access from its IDLE cycle; ack_at is the cycle index (0 = IDLE cycle) carrying mem_ack.
  task automatic access(input int ack_at, input int cycles, input logic [31:0] addr,
                        input logic we, input logic [31:0] wd, output int h, output int r);
    h = 0;
    r = 0;
    for (int i = 0; i < cycles; i++) begin
      mem_ack = (i == ack_at);
      #1;
      h += int'(holdreg);
      r += int'(mem_req);
      if (i == 1) begin
        chk("wait_addr", mem_addr, addr);
        chk("wait_we", {31'd0, mem_we}, {31'd0, we});
        chk("wait_wdata", mem_wdata, wd);
      end
      cyc();
      if (i == 0) begin
        control_signals = '0;
        aluresult = 32'h555;
        readdata2 = 32'h0;
      end
    end
    mem_ack = 0;
  endtask

  initial begin
    #2 rst_n = 0;
    #2;
    chk("rst_holdreg", {31'd0, holdreg}, 0);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_wb_valid", {31'd0, WB_VALID}, 0);
    chk("rst_mem_err", {31'd0, mem_err}, 0);
    cyc();
    #3 rst_n = 1;
    cyc();

    control_signals = 7'b01_00_1_0_0; aluresult = 32'h10; inst15to11 = 5'd7; inst20to16 = 5'd3; newpc = 32'h44;
    #1 chk("alu_holdreg", {31'd0, holdreg}, 0);
    cyc();
    chk("alu_valid", {31'd0, WB_VALID}, 1);
    chk("alu_dest", {27'd0, WB_DEST}, 7);
    chk("alu_result", WB_ALURESULT, 32'h10);
    chk("alu_readdata", WB_READDATA, 0);
    chk("alu_newpc", WB_NEWPC, 32'h44);
    chk("alu_regwrite", {31'd0, WB_REGWRITE}, 1);

    control_signals = 7'b00_01_1_1_0; aluresult = 32'h100; inst20to16 = 5'd4; newpc = 32'h104;
    mem_rdata = 32'hDEADBEEF;
    access(4, 5, 32'h100, 1'b0, 32'h0, hc, rc);
    chk("load_hold_cycles", hc, 4);
    chk("load_req_cycles", rc, 4);
    chk("load_readdata", WB_READDATA, 32'hDEADBEEF);
    chk("load_dest", {27'd0, WB_DEST}, 4);
    chk("load_valid", {31'd0, WB_VALID}, 1);
    chk("load_memtoreg", {30'd0, WB_MEMTOREG}, 1);
    chk("load_newpc", WB_NEWPC, 32'h104);
    chk("load_req_after", {31'd0, mem_req}, 0);

    control_signals = 7'b00_00_0_0_1; aluresult = 32'h20; readdata2 = 32'hA5A5A5A5; newpc = 32'h200;
    access(1, 2, 32'h20, 1'b1, 32'hA5A5A5A5, hc, rc);
    chk("store_hold_cycles", hc, 1);
    chk("store_req_cycles", rc, 1);
    chk("store_regwrite", {31'd0, WB_REGWRITE}, 0);
    chk("store_valid", {31'd0, WB_VALID}, 1);
    chk("store_readdata", WB_READDATA, 0);
    chk("store_alu", WB_ALURESULT, 32'h20);

    chk("pre_tmo_err", {31'd0, mem_err}, 0);
    control_signals = 7'b00_01_1_1_0; aluresult = 32'h300; inst20to16 = 5'd9;
    access(-1, 5, 32'h300, 1'b0, 32'h0, hc, rc);
    chk("tmo_req_cycles", rc, 4);
    chk("tmo_hold_cycles", hc, 4);
    chk("tmo_valid", {31'd0, WB_VALID}, 0);
    chk("tmo_regwrite", {31'd0, WB_REGWRITE}, 0);
    chk("tmo_err", {31'd0, mem_err}, 1);
    chk("tmo_holdreg", {31'd0, holdreg}, 0);
    chk("tmo_req_off", {31'd0, mem_req}, 0);
    mem_ack = 1; mem_rdata = 32'h12345678; control_signals = 7'b00_00_1_0_0; aluresult = 32'h77;
    cyc();
    mem_ack = 0;
    chk("late_ack_valid", {31'd0, WB_VALID}, 1);
    chk("late_ack_readdata", WB_READDATA, 0);
    chk("late_ack_req", {31'd0, mem_req}, 0);

    control_signals = 7'b00_01_1_1_0; aluresult = 32'h400;
    cyc();
    cyc();
    chk("pre_rst_req", {31'd0, mem_req}, 1);
    rst_n = 0;
    #1;
    chk("arst_req", {31'd0, mem_req}, 0);
    chk("arst_hold", {31'd0, holdreg}, 0);
    chk("arst_err", {31'd0, mem_err}, 0);
    chk("arst_valid", {31'd0, WB_VALID}, 0);
    chk("arst_alu", WB_ALURESULT, 0);
    chk("arst_newpc", WB_NEWPC, 0);
    control_signals = '0;
    #2 rst_n = 1;
    cyc();

    control_signals = 7'b00_01_1_1_0; aluresult = 32'h102;
    #1;
    chk("mis_req", {31'd0, mem_req}, 0);
    chk("mis_hold", {31'd0, holdreg}, 0);
    cyc();
    chk("mis_valid", {31'd0, WB_VALID}, 0);
    chk("mis_regwrite", {31'd0, WB_REGWRITE}, 0);
    chk("mis_err", {31'd0, mem_err}, 1);
    chk("mis_req_after", {31'd0, mem_req}, 0);
    control_signals = 7'b00_01_1_1_1; aluresult = 32'h200;
    #1;
    chk("rw_hold", {31'd0, holdreg}, 0);
    cyc();
    chk("rw_valid", {31'd0, WB_VALID}, 0);
    chk("rw_req", {31'd0, mem_req}, 0);

    control_signals = 7'b10_10_1_0_0; newpc = 32'h1234;
    cyc();
    chk("jal_dest", {27'd0, WB_DEST}, 31);
    chk("jal_valid", {31'd0, WB_VALID}, 1);
    chk("jal_newpc", WB_NEWPC, 32'h1234);
    chk("jal_memtoreg", {30'd0, WB_MEMTOREG}, 2);
    chk("err_sticky", {31'd0, mem_err}, 1);

    control_signals = 7'b11_00_1_0_0;
    cyc();
    chk("rd11_dest", {27'd0, WB_DEST}, 0);
    chk("rd11_regwrite", {31'd0, WB_REGWRITE}, 0);
    chk("rd11_valid", {31'd0, WB_VALID}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
